// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the key-schedule sequencer and its rcon generator.
// Holds: byte/key typedefs, round count, sequencer state encoding, GF(2^8) xtime.
// No ports; imported by aes_rcon_gen and aes_key_sched_ctrl.
package aes_pkg;

  typedef logic [7:0]   ByteType;
  typedef logic [127:0] key_128;

  // Expansion rounds for AES-128.
  localparam int AES128_NR = 10;

  typedef enum logic [2:0] {
    KSC_IDLE,
    KSC_LOAD,
    KSC_OUT,
    KSC_SUB,
    KSC_STEP
  } ksc_state_t;

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic ByteType xtime(input ByteType b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: init loads 0x01, step advances by xtime, otherwise holds.
// Latency: new value visible the cycle after init/step. No backpressure.
// Ports: clk, nrst (async active-high), init, step, rcon (current constant).
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       init,
  input  logic       step,
  output logic [7:0] rcon
);

  ByteType rcon_q, rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (init) begin
      rcon_d = 8'h01;
    end else if (step) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      rcon_q <= 8'h01;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: loads the key into aes_key_gen, steps rounds 1..NR with
// rcon and S-box wait, and hands each round key out over rk_valid/rk_ready.
// Latency: idx 0 valid 2 cycles after start, then one key per SBOX_LAT+2 cycles.
// Backpressure: rk_ready low holds the FSM in OUT with rk_idx/rk_o stable.
// Ports: start/abort/key_i control in; kg_* drive aes_key_gen; rk_* round-key handshake;
// busy/done status. Optional reverse-order mode under macro AES_KSC_DEC_EN (adds dec).
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int SBOX_LAT = 1,
  parameter int NR       = AES128_NR
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic         abort,
`ifdef AES_KSC_DEC_EN
  input  logic         dec,
`endif
  input  logic [127:0] key_i,
  input  logic [127:0] kg_key_o,
  output logic         kg_en,
  output logic         kg_gen_key,
  output logic         kg_next_rnd,
  output logic [7:0]   kg_rcon,
  output logic [127:0] kg_key_i,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_o,
  output logic         busy,
  output logic         done
);

  ksc_state_t   state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   cnt_q, cnt_d;
  key_128       key_q, key_d;
  logic         dec_q, dec_d;
  logic         rev_q, rev_d;     // presenting stored keys NR..0
  logic         busy_q, busy_d;
  logic         gen_key_q, gen_key_d;
  logic         next_rnd_q, next_rnd_d;
  ByteType      rcon_out_q, rcon_out_d;
  logic         rk_valid_q, rk_valid_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic         done_q, done_d;

  logic         rcon_init;
  logic         rcon_step;
  ByteType      rcon;
  logic         dec_in;
  key_128       rk_sel_dat;

  aes_rcon_gen u_rcon (
    .clk  (clk),
    .nrst (nrst),
    .init (rcon_init),
    .step (rcon_step),
    .rcon (rcon)
  );

  // rcon is consumed during STEP and advances on the edge that leaves it.
  assign rcon_step = (state_q == KSC_STEP);

`ifdef AES_KSC_DEC_EN
  logic   buf_we;
  key_128 rk_buf_q [NR+1];

  assign dec_in = dec;
  // During reverse-mode expansion every OUT cycle stores the generator output.
  assign buf_we = (state_q == KSC_OUT) && dec_q && !rev_q;

  always_ff @(posedge clk) begin
    if (buf_we) begin
      rk_buf_q[round_q] <= kg_key_o;
    end
  end

  assign rk_sel_dat = rev_q ? rk_buf_q[round_q] : kg_key_o;
`else
  assign dec_in     = 1'b0;
  assign rk_sel_dat = kg_key_o;
`endif

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    dec_d     = dec_q;
    rev_d     = rev_q;
    done_d    = 1'b0;
    rcon_init = 1'b0;

    unique case (state_q)
      KSC_IDLE: begin
        if (start && !abort) begin
          state_d   = KSC_LOAD;
          key_d     = key_i;
          round_d   = 4'd0;
          dec_d     = dec_in;
          rev_d     = 1'b0;
          rcon_init = 1'b1;
        end
      end
      KSC_LOAD: state_d = KSC_OUT;
      KSC_OUT: begin
        if (dec_q && !rev_q) begin
          // Storing pass: one cycle per round, no handshake.
          if (round_q == 4'(NR)) begin
            rev_d = 1'b1;
          end else begin
            state_d = KSC_SUB;
            cnt_d   = 2'(SBOX_LAT - 1);
          end
        end else if (rk_ready) begin
          if (rev_q) begin
            if (round_q == 4'd0) begin
              state_d = KSC_IDLE;
              done_d  = 1'b1;
            end else begin
              round_d = round_q - 4'd1;
            end
          end else if (round_q == 4'(NR)) begin
            state_d = KSC_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = KSC_SUB;
            cnt_d   = 2'(SBOX_LAT - 1);
          end
        end
      end
      KSC_SUB: begin
        if (cnt_q == 2'd0) begin
          state_d = KSC_STEP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      KSC_STEP: begin
        state_d = KSC_OUT;
        round_d = round_q + 4'd1;
      end
      default: state_d = KSC_IDLE;
    endcase

    // abort beats any handshake in the same cycle and suppresses done.
    if (abort && (state_q != KSC_IDLE)) begin
      state_d = KSC_IDLE;
      done_d  = 1'b0;
    end

    // Outputs are registered alongside the state they belong to.
    busy_d     = (state_d != KSC_IDLE);
    gen_key_d  = (state_d == KSC_LOAD);
    next_rnd_d = (state_d == KSC_STEP);
    rcon_out_d = (state_d == KSC_STEP) ? rcon : 8'h00;
    rk_valid_d = (state_d == KSC_OUT) && (!dec_d || rev_d);
    rk_idx_d   = rk_valid_d ? round_d : 4'd0;
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q    <= KSC_IDLE;
      round_q    <= 4'd0;
      cnt_q      <= 2'd0;
      key_q      <= '0;
      dec_q      <= 1'b0;
      rev_q      <= 1'b0;
      busy_q     <= 1'b0;
      gen_key_q  <= 1'b0;
      next_rnd_q <= 1'b0;
      rcon_out_q <= 8'h00;
      rk_valid_q <= 1'b0;
      rk_idx_q   <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      dec_q      <= dec_d;
      rev_q      <= rev_d;
      busy_q     <= busy_d;
      gen_key_q  <= gen_key_d;
      next_rnd_q <= next_rnd_d;
      rcon_out_q <= rcon_out_d;
      rk_valid_q <= rk_valid_d;
      rk_idx_q   <= rk_idx_d;
      done_q     <= done_d;
    end
  end

  assign kg_en       = busy_q;
  assign busy        = busy_q;
  assign kg_gen_key  = gen_key_q;
  assign kg_next_rnd = next_rnd_q;
  assign kg_rcon     = rcon_out_q;
  assign kg_key_i    = key_q;
  assign rk_valid    = rk_valid_q;
  assign rk_idx      = rk_idx_q;
  assign rk_o        = rk_valid_q ? rk_sel_dat : '0;
  assign done        = done_q;

endmodule
